// File: rtl/conv2d_ctrl.sv
// conv2d_ctrl: 3x3 conv2d sequencer (kernel/bias load, pixel raster, window-valid tracking); CONV_CTRL_REUSE_CFG_EN adds reuse_cfg
module conv2d_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIPE_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef CONV_CTRL_REUSE_CFG_EN
  input  logic                       reuse_cfg,
`endif
  input  logic                       start,
  input  logic                       cfg_valid,
  input  logic [7:0]                 cfg_data,
  output logic                       cfg_ready,
  input  logic                       pix_valid,
  input  logic [7:0]                 pix_data,
  output logic                       pix_ready,
  output logic [7:0]                 dp_pixel,
  output logic                       dp_shift,
  output logic                       dp_cfg_we,
  output logic [3:0]                 dp_cfg_addr,
  output logic [7:0]                 dp_cfg_data,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       done
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int FW = $clog2(PIPE_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_idx;
  logic [RW-1:0] r_nrow, r_row;
  logic [CW-1:0] r_ncol, r_col;
  logic [FW-1:0] r_fcnt;
  logic [PIPE_LAT:0] r_dly;
  logic [7:0] r_pix, r_cdata;
  logic [3:0] r_addr;
  logic r_we, r_shift;
  logic w_cfg_hs, w_last_cfg, w_acc, w_col_end, w_last_pix, w_win, w_reuse;
  assign cfg_ready = r_state == LOAD;
  assign pix_ready = r_state == RUN;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign w_cfg_hs = cfg_valid & cfg_ready;
  assign w_last_cfg = w_cfg_hs & (r_idx == 4'd9);
  assign w_acc = pix_valid & pix_ready;
  assign w_col_end = r_ncol == CW'(IMG_W - 1);
  assign w_last_pix = w_acc & w_col_end & (r_nrow == RW'(IMG_H - 1));
  assign w_win = w_acc & (r_nrow >= RW'(2)) & (r_ncol >= CW'(2));
  assign dp_pixel = r_pix;
  assign dp_shift = r_shift;
  assign dp_cfg_we = r_we;
  assign dp_cfg_addr = r_addr;
  assign dp_cfg_data = r_cdata;
  assign row = r_row;
  assign col = r_col;
  assign out_valid = r_dly[PIPE_LAT];
`ifdef CONV_CTRL_REUSE_CFG_EN
  logic r_loaded;
  // remember that a full kernel+bias set is resident in the datapath
  always_ff @(posedge clk or posedge rst)
    if (rst) r_loaded <= 1'b0;
    else if (w_last_cfg) r_loaded <= 1'b1;
  assign w_reuse = reuse_cfg & r_loaded;
`else
  assign w_reuse = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next-state: flush holds until the last window result has left the datapath
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_reuse ? RUN : LOAD;
      LOAD:    if (w_last_cfg) w_next = RUN;
      RUN:     if (w_last_pix) w_next = FLUSH;
      FLUSH:   if (r_fcnt == FW'(PIPE_LAT)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // config stream: register each accepted word as a datapath write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_cdata <= '0;
    end else begin
      r_idx <= (r_state == LOAD) ? r_idx + 4'(w_cfg_hs) : '0;
      r_we <= w_cfg_hs;
      if (w_cfg_hs) begin
        r_addr <= r_idx;
        r_cdata <= cfg_data;
      end
    end
  // pixel path: next-position counters, registered pixel/position, window delay line
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_nrow <= '0;
      r_ncol <= '0;
      r_row <= '0;
      r_col <= '0;
      r_pix <= '0;
      r_shift <= 1'b0;
      r_fcnt <= '0;
      r_dly <= '0;
    end else begin
      r_shift <= w_acc;
      if (w_acc) begin
        r_pix <= pix_data;
        r_row <= r_nrow;
        r_col <= r_ncol;
      end
      r_ncol <= (r_state != RUN) ? '0 : w_acc ? (w_col_end ? '0 : r_ncol + CW'(1)) : r_ncol;
      r_nrow <= (r_state != RUN) ? '0 : (w_acc & w_col_end) ? r_nrow + RW'(1) : r_nrow;
      r_fcnt <= (r_state == FLUSH) ? r_fcnt + FW'(1) : '0;
      r_dly <= {r_dly[PIPE_LAT-1:0], w_win};
    end
endmodule

// File: tb/tb_conv2d_ctrl.sv
// tb_conv2d_ctrl: randomized frames checked cycle-by-cycle against a cycle-indexed expectation model
module tb_conv2d_ctrl;
  localparam int W = 4, H = 4, P = 1, N = 4096;
`ifdef CONV_CTRL_REUSE_CFG_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, cfg_valid = 0, pix_valid = 0, reuse_cfg = 0;
  logic [7:0] cfg_data = 0, pix_data = 0;
  logic cfg_ready, pix_ready, dp_shift, dp_cfg_we, out_valid, busy, done;
  logic [7:0] dp_pixel, dp_cfg_data;
  logic [3:0] dp_cfg_addr;
  logic [1:0] row, col;

  conv2d_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(P)) dut (
    .clk(clk), .rst(rst),
`ifdef CONV_CTRL_REUSE_CFG_EN
    .reuse_cfg(reuse_cfg),
`endif
    .start(start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .dp_pixel(dp_pixel), .dp_shift(dp_shift), .dp_cfg_we(dp_cfg_we),
    .dp_cfg_addr(dp_cfg_addr), .dp_cfg_data(dp_cfg_data), .row(row), .col(col),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit e_shift[N], e_ov[N], e_we[N];
  int e_pix[N], e_row[N], e_col[N], e_addr[N], e_cdat[N];
  int mph = 0, mcnt = 0, mend = 0, mpix = 0, mrow = 0, mcol = 0;
  bit mloaded = 0;
  int n_we, n_ov, n_shift, n_done, ppix;
  bit pshift;
  int ov_pix[$], we_dat[$];
  bit first_pr, first_cr;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // model phases: 0 idle, 1 loading cfg, 2 streaming pixels, 3 draining pipeline, 4 done pulse
  always @(negedge clk) begin
    int c, j, n1;
    c = cyc % N;
    if (rst) begin
      for (int i = 0; i < P + 3; i++) begin
        j = (c + i) % N;
        e_shift[j] = 0; e_ov[j] = 0; e_we[j] = 0;
      end
      mph = 0; mcnt = 0; mpix = 0; mrow = 0; mcol = 0; mloaded = 0;
    end
    if (e_shift[c]) begin mpix = e_pix[c]; mrow = e_row[c]; mcol = e_col[c]; end
    chk("cfg_ready", cfg_ready, mph == 1);
    chk("pix_ready", pix_ready, mph == 2);
    chk("busy", busy, mph != 0);
    chk("done", done, mph == 4);
    chk("dp_shift", dp_shift, e_shift[c]);
    chk("dp_pixel", dp_pixel, mpix);
    chk("row", row, mrow);
    chk("col", col, mcol);
    chk("out_valid", out_valid, e_ov[c]);
    chk("dp_cfg_we", dp_cfg_we, e_we[c]);
    if (e_we[c]) begin
      chk("dp_cfg_addr", dp_cfg_addr, e_addr[c]);
      chk("dp_cfg_data", dp_cfg_data, e_cdat[c]);
    end
    if (!rst) begin
      n_we += dp_cfg_we; n_ov += out_valid; n_shift += dp_shift; n_done += done;
      if (dp_cfg_we) we_dat.push_back(dp_cfg_data);
      if (out_valid && pshift) ov_pix.push_back(ppix);
      pshift = dp_shift; ppix = dp_pixel;
    end
    e_shift[c] = 0; e_ov[c] = 0; e_we[c] = 0;
    n1 = (c + 1) % N;
    if (!rst)
      case (mph)
        0: if (start) begin mph = (REUSE && reuse_cfg && mloaded) ? 2 : 1; mcnt = 0; end
        1: if (cfg_valid) begin
             e_we[n1] = 1; e_addr[n1] = mcnt; e_cdat[n1] = cfg_data; mcnt++;
             if (mcnt == 10) begin mph = 2; mcnt = 0; mloaded = 1; end
           end
        2: if (pix_valid) begin
             e_shift[n1] = 1; e_pix[n1] = pix_data; e_row[n1] = mcnt / W; e_col[n1] = mcnt % W;
             if (mcnt / W >= 2 && mcnt % W >= 2) e_ov[(c + 1 + P) % N] = 1;
             mcnt++;
             if (mcnt == W * H) begin mph = 3; mend = cyc + 1 + P; end
           end
        3: if (cyc == mend) mph = 4;
        default: mph = 0;
      endcase
  end

  // mode 0: back-to-back, 1: valid toggling, 2: random valids/data plus stray start pulses
  task automatic frame(input int mode, input bit reuse, input int abort_n);
    int k, n, g;
    k = 0; n = 0; g = 0;
    n_we = 0; n_ov = 0; n_shift = 0; n_done = 0;
    ov_pix.delete(); we_dat.delete();
    start = 1; reuse_cfg = reuse;
    step();
    start = 0;
    first_pr = pix_ready; first_cr = cfg_ready;
    while (busy && g < 3000) begin
      if (abort_n > 0 && n == abort_n) begin
        rst = 1; cfg_valid = 0; pix_valid = 0;
        #1;
        chk("abort_outs", {cfg_ready, pix_ready, dp_shift, dp_cfg_we, out_valid, busy, done}, 0);
        chk("abort_pixel", dp_pixel, 0);
        chk("abort_rowcol", {row, col}, 0);
        step();
        rst = 0;
        break;
      end
      cfg_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
      pix_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
      cfg_data = (mode == 2) ? 8'($urandom) : (k < 9 ? 8'(k + 1) : 8'd5);
      pix_data = (mode == 2) ? 8'($urandom) : 8'(n);
      start = (mode == 2) && pix_ready && ($urandom_range(0, 3) == 0);
      k += int'(cfg_valid && cfg_ready);
      n += int'(pix_valid && pix_ready);
      step();
      g++;
    end
    cfg_valid = 0; pix_valid = 0; start = 0;
    if (g >= 3000) chk("frame_timeout", 1, 0);
  endtask

  task automatic frame_literals(input bit ordered);
    chk("n_ov", n_ov, 4);
    chk("n_shift", n_shift, 16);
    chk("n_done", n_done, 1);
    chk("busy_after", busy, 0);
    if (ordered) begin
      chk("n_we", n_we, 10);
      chk("ov_cnt", ov_pix.size(), 4);
      chk("ov_pix0", ov_pix[0], 10);
      chk("ov_pix1", ov_pix[1], 11);
      chk("ov_pix2", ov_pix[2], 14);
      chk("ov_pix3", ov_pix[3], 15);
      for (int i = 0; i < 10; i++) chk("cfg_seq", we_dat[i], i < 9 ? i + 1 : 5);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1;
    repeat (2) step();
    chk("reset_outs", {cfg_ready, pix_ready, dp_shift, dp_cfg_we, out_valid, busy, done}, 0);
    chk("reset_cfg", {dp_cfg_addr, dp_cfg_data}, 0);
    chk("reset_pix", {dp_pixel, row, col}, 0);
    rst = 0;
    step();
    frame(0, 0, 0);
    chk("load_entered", first_cr, 1);
    frame_literals(1);
    frame(1, 0, 0);
    frame_literals(1);
    repeat (3) begin
      frame(2, 0, 0);
      frame_literals(0);
    end
    frame(0, 0, 7);
    chk("abort_no_done", n_done, 0);
    step();
    frame(0, 1, 0);
    chk("relaod_after_rst", first_cr, 1);
    chk("reload_we", n_we, 10);
    frame_literals(1);
    if (REUSE) begin
      frame(2, 1, 0);
      chk("reuse_pix_ready", first_pr, 1);
      chk("reuse_no_we", n_we, 0);
      frame(0, 0, 0);
      chk("noreuse_load", first_cr, 1);
      frame_literals(1);
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv2d_ctrl.md
Name: conv2d_ctrl

Overview:
Sequencer for the 3x3 conv2d datapath. Loads the 9 kernel weights and the bias through a config stream, then rasters one IMG_W x IMG_H frame of 8-bit pixels into the datapath with valid/ready flow control. Tracks row and column, and flags which datapath outputs correspond to fully populated 3x3 windows. Sits between the pixel source (line buffer/DMA) and the conv2d engine.

Parameters:
IMG_W, 28, frame width in pixels (>=3)
IMG_H, 28, frame height in pixels (>=3)
PIPE_LAT, 1, datapath cycles from pixel shift to valid conv result (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin frame; sampled only in IDLE
cfg_valid  in  1  config word valid
cfg_data  in  8  kernel word 0..8, then bias
cfg_ready  out  1  high only in LOAD
pix_valid  in  1  pixel valid
pix_data  in  8  pixel, raster order
pix_ready  out  1  high only in RUN
dp_pixel  out  8  pixel to datapath, registered
dp_shift  out  1  one-cycle window-shift strobe per accepted pixel
dp_cfg_we  out  1  datapath weight write strobe
dp_cfg_addr  out  4  0..8 kernel index, 9 = bias
dp_cfg_data  out  8  weight/bias value
row  out  $clog2(IMG_H)  row of last accepted pixel
col  out  $clog2(IMG_W)  column of last accepted pixel
out_valid  out  1  datapath output is a valid window result
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; all outputs 0; cfg index, row/col counters, out_valid delay line cleared. Reset mid-frame aborts immediately; no done pulse.
- States: IDLE -> LOAD on start. LOAD -> RUN after 10th cfg handshake. RUN -> FLUSH after pixel (IMG_H-1, IMG_W-1) accepted. FLUSH -> DONE after PIPE_LAT cycles. DONE -> IDLE after 1 cycle.
- start ignored outside IDLE.
- LOAD: each cycle with cfg_valid & cfg_ready registers dp_cfg_we=1, dp_cfg_addr=index, dp_cfg_data=cfg_data (1-cycle latency); index 0..9, cleared on entering LOAD.
- RUN: accept when pix_valid & pix_ready. Next cycle: dp_shift=1, dp_pixel=pix_data, row/col = position. No accept -> dp_shift=0, dp_pixel holds, counters hold.
- Col increments per accept, wraps IMG_W-1 -> 0 with row+1. Row does not wrap; last pixel ends RUN; pix_ready drops the cycle after the last accept.
- Window valid when accepted pixel has row>=2 and col>=2. out_valid pulses exactly PIPE_LAT cycles after that pixel's dp_shift cycle. Delay line advances every cycle regardless of stalls. Stalls do not alter delay alignment.
- Last pixel: final out_valid pulse occurs in FLUSH; done asserts in DONE, strictly after the last out_valid.
- busy = 1 in LOAD, RUN, FLUSH, DONE.
- Per-frame count of out_valid pulses = (IMG_W-2)*(IMG_H-2).

Optional Feature:
CONV_CTRL_REUSE_CFG_EN: when defined, adds input reuse_cfg (1 bit) and an internal cfg_loaded flag. cfg_loaded is set on LOAD completion and cleared by rst. start with reuse_cfg=1 and cfg_loaded=1 goes IDLE -> RUN directly, skipping LOAD; otherwise goes to LOAD. When undefined: no port, every start goes through LOAD.

Test Plan:
- Reset, then start; feed cfg words 1..9 then bias 5 -> dp_cfg_we pulses 10x, addr 0..9, data 1..9,5; cfg_ready drops after 10th; pix_ready rises.
- IMG_W=4, IMG_H=4, PIPE_LAT=1, pixels 0..15 back-to-back -> out_valid exactly 4 pulses, 1 cycle after dp_shift of pixels 10,11,14,15; done 1 cycle after FLUSH; busy low after.
- Same frame with pix_valid toggling 1/0 -> same 4 out_valid pulses, each 1 cycle after its dp_shift; counters hold during gaps; dp_shift count = 16.
- Assert rst after 7th pixel -> all outputs 0 same cycle; no done; next start re-enters LOAD with index 0.
- Pulse start during RUN -> ignored; frame completes with exactly one done.
- With CONV_CTRL_REUSE_CFG_EN: second frame with reuse_cfg=1 -> no dp_cfg_we, pix_ready high 1 cycle after start; with reuse_cfg=0 -> LOAD entered.
